// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg -- shared definitions for the program-counter sequencer.
//   INSTR_W     : instruction word width (16)
//   FKEQ..HALT  : opcode constants (instr[15:12])
//   state_t     : sequencer state encoding
//   is_fork()   : true for the conditional-branch (fork) opcodes
package pc_sequencer_pkg;

  localparam int unsigned INSTR_W = 16;

  localparam logic [3:0] FKEQ = 4'b0000;
  localparam logic [3:0] FKNE = 4'b0001;
  localparam logic [3:0] FKLT = 4'b0010;
  localparam logic [3:0] FKLE = 4'b0011;
  localparam logic [3:0] FKGT = 4'b1000;
  localparam logic [3:0] FKGE = 4'b1001;
  localparam logic [3:0] JUMP = 4'b1010;
  localparam logic [3:0] HALT = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_HALT
  } state_t;

  function automatic logic is_fork(input logic [3:0] op);
    case (op)
      FKEQ, FKNE, FKLT, FKLE, FKGT, FKGE: is_fork = 1'b1;
      default:                            is_fork = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc -- combinational next-PC selection.
//   pc         : current program counter (N bits)
//   instr      : instruction being accepted (16 bits)
//   fork_taken : fork condition result for this instruction
//   pc_next    : next program counter (N bits, modulo 2^N)
// JUMP loads the low address field; fork opcodes add a sign-extended
// 6-bit offset to PC+1 when taken; everything else advances by one.
module pc_next_calc
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned N = 10
) (
  input  logic [N-1:0]       pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               fork_taken,
  output logic [N-1:0]       pc_next
);

  logic [3:0]   op;
  logic [N-1:0] pc_inc;
  logic [N-1:0] fork_off;
  logic [N-1:0] jump_tgt;

  assign op       = instr[INSTR_W-1 -: 4];
  assign pc_inc   = pc + N'(1);
  // Sign-extend the 6-bit offset to N bits; the add then wraps mod 2^N.
  assign fork_off = N'(signed'(instr[5:0]));
  // Address field below the opcode; truncated (or zero-extended) to N.
  assign jump_tgt = N'(instr[INSTR_W-5:0]);

  always_comb begin
    pc_next = pc_inc;
    if (op == JUMP) begin
      pc_next = jump_tgt;
    end else if (is_fork(op) && fork_taken) begin
      pc_next = pc_inc + fork_off;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch/issue program sequencer with fork/jump/halt.
//   clk         : system clock (rising edge)
//   rst         : asynchronous active-low reset
//   start       : one-cycle pulse, begins fetching at PC 0 from IDLE
//   step        : single-step pulse (only with PC_SEQUENCER_STEP_MODE_EN)
//   pm_addr     : program memory address (= PC)
//   pm_data     : instruction word from program memory
//   instr       : registered instruction to datapath
//   instr_valid : instr valid, held until dp_ready
//   dp_ready    : datapath accept
//   fork_taken  : fork condition, sampled in the acceptance cycle
//   halted      : HALT executed; left only by reset
// Optional build macro: PC_SEQUENCER_STEP_MODE_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned N = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef PC_SEQUENCER_STEP_MODE_EN
  input  logic               step,
`endif
  output logic [N-1:0]       pm_addr,
  input  logic [INSTR_W-1:0] pm_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               dp_ready,
  input  logic               fork_taken,
  output logic               halted
);

  state_t       state, state_nxt;
  logic [N-1:0] pc;
  logic [N-1:0] pc_next;
  logic         accept;

  assign accept = (state == ST_ISSUE) && dp_ready;

  pc_next_calc #(.N(N)) u_next (
    .pc         (pc),
    .instr      (instr),
    .fork_taken (fork_taken),
    .pc_next    (pc_next)
  );

`ifdef PC_SEQUENCER_STEP_MODE_EN
  // Step mode parks in IDLE with step_wait set after start or after an
  // acceptance; the next step pulse launches exactly one FETCH.
  logic step_wait, step_wait_nxt;

  always_comb begin
    state_nxt     = state;
    step_wait_nxt = step_wait;
    case (state)
      ST_IDLE: begin
        if (step_wait && step) begin
          state_nxt     = ST_FETCH;
          step_wait_nxt = 1'b0;
        end else if (start) begin
          step_wait_nxt = 1'b1;
        end
      end
      ST_FETCH: state_nxt = (pm_data[INSTR_W-1 -: 4] == HALT) ? ST_HALT : ST_ISSUE;
      ST_ISSUE: begin
        if (dp_ready) begin
          state_nxt     = ST_IDLE;
          step_wait_nxt = 1'b1;
        end
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_wait <= 1'b0;
    end else begin
      step_wait <= step_wait_nxt;
    end
  end
`else
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = (pm_data[INSTR_W-1 -: 4] == HALT) ? ST_HALT : ST_ISSUE;
      ST_ISSUE: if (dp_ready) state_nxt = ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      pc    <= '0;
      instr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH) begin
        instr <= pm_data;
      end
      if (accept) begin
        pc <= pc_next;
      end
    end
  end

  assign pm_addr     = pc;
  assign instr_valid = (state == ST_ISSUE);
  assign halted      = (state == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int unsigned N = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           dp_ready;
  logic           fork_taken;
  logic           instr_valid;
  logic           halted;
  logic [N-1:0]   pm_addr;
  logic [15:0]    pm_data;
  logic [15:0]    instr;
  logic [15:0]    mem [0:1023];
  logic           fork_used;
  int             cyc = 0;
`ifdef PC_SEQUENCER_STEP_MODE_EN
  logic           step = 1'b1;
`endif

  pc_sequencer #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef PC_SEQUENCER_STEP_MODE_EN
    .step        (step),
`endif
    .pm_addr     (pm_addr),
    .pm_data     (pm_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .dp_ready    (dp_ready),
    .fork_taken  (fork_taken),
    .halted      (halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous-read program memory.
  assign pm_data = mem[pm_addr];

  // Only the first fork accepted after reset is taken.
  assign fork_taken = !fork_used;
  always @(posedge clk or negedge rst) begin
    if (!rst) fork_used <= 1'b0;
    else if (instr_valid && dp_ready && is_fork(instr[15:12])) fork_used <= 1'b1;
  end

  typedef struct {
    int unsigned addr;
    logic [15:0] ins;
    int          gap;   // required cycles since previous issue, 0 = don't care
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
  endtask

  task automatic push(input int unsigned addr, input logic [15:0] ins, input int gap);
    exp_t e;
    e.addr = addr;
    e.ins  = ins;
    e.gap  = gap;
    q.push_back(e);
  endtask

  // Monitor: compares every accepted instruction against the scoreboard.
  initial begin
    exp_t e;
    int   last;
    last = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && instr_valid === 1'b1 && dp_ready === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_issue: got addr %0d instr 0x%0h, required none", pm_addr, instr);
        end else begin
          e = q.pop_front();
          check("issue_addr", pm_addr, e.addr);
          check("issue_instr", instr, e.ins);
          if (e.gap != 0) check("issue_gap", cyc - last, e.gap);
        end
        last = cyc;
      end
    end
  end

  task automatic fill();
    for (int unsigned i = 0; i < 1024; i++) mem[i] = 16'h4000;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    start    = 1'b0;
    dp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Run until the scoreboard empties, then stop accepting.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    dp_ready = 1'b0;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_halted(input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", halted, 1);
  endtask

  initial begin
    int n;
    rst      = 1'b0;
    start    = 1'b0;
    dp_ready = 1'b0;
    fill();

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_pm_addr", pm_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_valid", instr_valid, 0);
    check("idle_pm_addr", pm_addr, 0);

    // Run 1: straight line, fork taken/not taken, jumps, halt.
    mem[0]  = 16'h4001;
    mem[1]  = 16'h4002;
    mem[2]  = 16'h4003;
    mem[3]  = 16'hA008;
    mem[8]  = 16'h0042;
    mem[11] = 16'hA008;
    mem[9]  = 16'hA017;
    mem[23] = 16'hA015;
    mem[21] = 16'hA018;
    mem[24] = 16'hE000;
    push(0,  16'h4001, 0);
    push(1,  16'h4002, 2);
    push(2,  16'h4003, 2);
    push(3,  16'hA008, 2);
    push(8,  16'h0042, 2);
    push(11, 16'hA008, 2);
    push(8,  16'h0042, 2);
    push(9,  16'hA017, 2);
    push(23, 16'hA015, 2);
    push(21, 16'hA018, 2);
    dp_ready = 1'b1;
    pulse_start();
    drain(200);
    wait_halted(20);
    check("halt_pm_addr", pm_addr, 24);
    check("halt_instr", instr, 16'hE000);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (instr_valid !== 1'b0) n++;
    end
    check("halt_valid_rises", n, 0);
    pulse_start();
    @(negedge clk);
    check("halt_ignores_start", halted, 1);
    check("halt_ignores_start_valid", instr_valid, 0);

    // Run 2: datapath stall holds the issued instruction.
    do_reset();
    fill();
    mem[0] = 16'h4001;
    mem[1] = 16'hE000;
    pulse_start();
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid_seen", instr_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_instr", instr, 16'h4001);
      check("stall_pm_addr", pm_addr, 0);
      check("stall_valid", instr_valid, 1);
    end
    push(0, 16'h4001, 0);
    @(posedge clk);
    #1 dp_ready = 1'b1;
    drain(50);
    wait_halted(20);

    // Run 3: negative fork offset wrap and PC 1023 wrap.
    do_reset();
    fill();
    mem[0]    = 16'h803F;
    mem[1]    = 16'hA3FF;
    mem[1023] = 16'h4000;
    push(0,    16'h803F, 0);
    push(0,    16'h803F, 2);
    push(1,    16'hA3FF, 2);
    push(1023, 16'h4000, 2);
    push(0,    16'h803F, 2);
    dp_ready = 1'b1;
    pulse_start();
    drain(200);

    // Run 4: asynchronous reset in the middle of ISSUE.
    repeat (3) @(negedge clk);
    check("pre_rst_valid", instr_valid, 1);
    check("pre_rst_pm_addr", pm_addr, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_pm_addr", pm_addr, 0);
    check("async_rst_instr", instr, 0);
    check("async_rst_valid", instr_valid, 0);
    check("async_rst_halted", halted, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_valid", instr_valid, 0);
    check("post_rst_pm_addr", pm_addr, 0);
    check("post_rst_halted", halted, 0);
    push(0, 16'h803F, 0);
    dp_ready = 1'b1;
    pulse_start();
    drain(50);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
